circuito_top: RTL and testbench
===============================

// Module: circuito_top
// PURPOSE
// Top level of the serial-configured servo dispenser. An 8N1 UART receiver
// gets ASCII command frames from the host, a parser stores min, max and current
// weight as two-digit decimal values, and a comparator sets the servo pulse width.
// Output is a 50 Hz servo PWM. The bench drives entrada_serial from tx_serial_8N1_nandland.
// PARAMETERS
// CLKS_PER_BIT  434        clocks per UART bit (50 MHz / 115200 baud)
// PWM_PERIOD    1_000_000  clocks per PWM frame (20 ms)
// PULSE_CLOSED  50_000     high time, 1.0 ms: weight >= max, gate closed
// PULSE_HALF    75_000     high time, 1.5 ms: min <= weight < max
// PULSE_OPEN    100_000    high time, 2.0 ms: weight < min, gate fully open
// PORTS
// clock           in   1  system clock, 50 MHz, rising edge
// reset           in   1  asynchronous, active-high; clears all state
// entrada_serial  in   1  UART RX line, idle high, 8N1, LSB first
// pwm             out  1  servo PWM
// BEHAVIOUR
// Interface: one clock; reset is asynchronous and active-high.
// - entrada_serial passes through a 2-FF synchronizer; both FFs reset to 1.
// - RX FSM IDLE->START->DATA->STOP:
//   - IDLE: a falling edge moves to START.
//   - START: sample at CLKS_PER_BIT/2. If the line is high again, it is a glitch: go back to IDLE.
//   - DATA: sample 8 bits, one every CLKS_PER_BIT clocks, LSB first.
//   - STOP: sample the stop bit. If it is 1, pulse rx_valid for 1 clock with the byte. If it is 0 (framing error), drop the byte silently.
// - Parser FSM WAIT_CMD->D0..D5:
//   - WAIT_CMD: byte 0x30 ('0') is the set-config command and moves to D0. Any other byte is ignored.
//   - D0..D5: accept 6 ASCII digits (0x30..0x39) in order: min tens, min units, max tens, max units, weight tens, weight units.
//   - Each value = tens*10 + units, 7-bit unsigned, range 0..99.
//   - A non-digit byte in D0..D5 aborts the frame: return to WAIT_CMD and leave the registers unchanged.
//   - After the 6th digit, update min, max and weight together in the same clock, then return to WAIT_CMD.
// - Reset values: min=0, max=0, weight=0. Parser in WAIT_CMD, RX in IDLE.
// - Pulse width select (unsigned compare):
//   - weight < min -> PULSE_OPEN
//   - else weight >= max -> PULSE_CLOSED
//   - else -> PULSE_HALF
//   - Since min is checked first, min > max with weight < min gives OPEN.
// - PWM: a 20-bit counter runs 0..PWM_PERIOD-1 and wraps. pwm = (counter < latched_width).
//   latched_width is loaded when counter == 0, so the pulse never glitches mid-frame.
//   New settings appear at the next frame start (at most 20 ms latency).
// - After reset: counter=0, pwm=0, latched_width=PULSE_CLOSED.
//   pwm goes high the first clock after reset releases.
// - Reset mid-frame or mid-byte: all state is discarded at once. Afterwards the parser needs a fresh 0x30.
// - A new command byte arriving in D0..D5 is a digit (0x30) and is stored as digit 0. There is no resync.
// TESTING
// - Reset 200 ns then idle 1 ms -> pwm period 1_000_000 clocks, high 50_000 clocks.
// - Send 30 31 30 32 30 31 35 (min 10, max 20, weight 15) at 434 clk/bit -> from the next frame, pwm high 75_000 clocks.
// - Send 30 31 30 32 30 30 35 (weight 5) -> high 100_000. Then 30 31 30 32 30 32 30 (weight 20) -> high 50_000.
// - Send 30 31 41 ... (non-digit 'A' in D1) -> frame aborted; registers and pulse width unchanged.
// - Send a byte with stop bit 0, or a start glitch shorter than 217 clocks -> no byte accepted; parser state unchanged.
// - Assert reset in the middle of a frame after 3 digits -> pwm=0 at once; width back to 50_000; partial frame lost.

Source files
------------

// File: rtl/circuito_top.sv
// Serial-configured servo dispenser: 8N1 UART receiver, ASCII config parser,
// weight comparator and glitch-free 50 Hz servo PWM.
module circuito_top #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PWM_PERIOD   = 1_000_000,
    parameter int PULSE_CLOSED = 50_000,
    parameter int PULSE_HALF   = 75_000,
    parameter int PULSE_OPEN   = 100_000
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada_serial,
    output logic pwm
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [19:0] W_CLOSED = 20'(PULSE_CLOSED);
    localparam logic [19:0] W_HALF   = 20'(PULSE_HALF);
    localparam logic [19:0] W_OPEN   = 20'(PULSE_OPEN);
    localparam logic [19:0] PER_LAST = 20'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_WAIT, P_D0, P_D1, P_D2, P_D3, P_D4, P_D5} p_state_t;

    logic sync1, sync2, sync_prev;
    rx_state_t rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic rx_valid_q, rx_valid_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync_prev  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            sync1      <= entrada_serial;
            sync2      <= sync1;
            sync_prev  <= sync2;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!sync2 && sync_prev) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_byte_d[rx_bit_q] = sync2;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = sync2;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    function automatic logic [6:0] to_val(input logic [3:0] t, input logic [3:0] u);
        return 7'(t) * 7'd10 + 7'(u);
    endfunction

    p_state_t p_state_q, p_state_d;
    logic [3:0] dig_q [0:4];
    logic [3:0] dig_d [0:4];
    logic [6:0] min_q, max_q, wt_q;
    logic commit;
    logic is_digit;
    logic [3:0] digit;

    assign is_digit = (rx_byte_q >= 8'h30) && (rx_byte_q <= 8'h39);
    assign digit    = rx_byte_q[3:0];

    // The last digit is used straight off the receiver so all three values update together.
    always_comb begin
        p_state_d = p_state_q;
        dig_d     = dig_q;
        commit    = 1'b0;
        if (rx_valid_q) begin
            if (p_state_q == P_WAIT) begin
                if (rx_byte_q == 8'h30) p_state_d = P_D0;
            end else if (!is_digit) begin
                p_state_d = P_WAIT;
            end else begin
                case (p_state_q)
                    P_D0: begin dig_d[0] = digit; p_state_d = P_D1; end
                    P_D1: begin dig_d[1] = digit; p_state_d = P_D2; end
                    P_D2: begin dig_d[2] = digit; p_state_d = P_D3; end
                    P_D3: begin dig_d[3] = digit; p_state_d = P_D4; end
                    P_D4: begin dig_d[4] = digit; p_state_d = P_D5; end
                    default: begin commit = 1'b1; p_state_d = P_WAIT; end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_state_q <= P_WAIT;
            for (int unsigned i = 0; i < 5; i++) dig_q[i] <= '0;
            min_q <= '0;
            max_q <= '0;
            wt_q  <= '0;
        end else begin
            p_state_q <= p_state_d;
            dig_q     <= dig_d;
            if (commit) begin
                min_q <= to_val(dig_q[0], dig_q[1]);
                max_q <= to_val(dig_q[2], dig_q[3]);
                wt_q  <= to_val(dig_q[4], digit);
            end
        end
    end

    logic [19:0] width_sel, active_width, latched_width, counter;

    always_comb begin
        if (wt_q < min_q)       width_sel = W_OPEN;
        else if (wt_q >= max_q) width_sel = W_CLOSED;
        else                    width_sel = W_HALF;
        active_width = (counter == '0) ? width_sel : latched_width;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter       <= '0;
            latched_width <= W_CLOSED;
            pwm           <= 1'b0;
        end else begin
            counter <= (counter == PER_LAST) ? '0 : counter + 1'b1;
            if (counter == '0) latched_width <= width_sel;
            pwm <= (counter < active_width);
        end
    end
endmodule

// File: tb/tb_circuito_top.sv
// Scoreboard bench for circuito_top: UART byte driver, behavioural config model,
// and a frame monitor that measures pwm high time and period.
`timescale 1ns/1ps
module tb_circuito_top;
    localparam int CPB    = 8;
    localparam int PER    = 800;
    localparam int W_CL   = 50;
    localparam int W_HF   = 75;
    localparam int W_OP   = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic entrada_serial = 1'b1;
    logic pwm;

    circuito_top #(
        .CLKS_PER_BIT(CPB),
        .PWM_PERIOD(PER),
        .PULSE_CLOSED(W_CL),
        .PULSE_HALF(W_HF),
        .PULSE_OPEN(W_OP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .entrada_serial(entrada_serial),
        .pwm(pwm)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    // Reference model: configuration registers and the digits of a frame in progress
    int m_min = 0, m_max = 0, m_wt = 0;
    bit m_in_frame = 0;
    int m_digits[$];

    function automatic int model_width();
        if (m_wt < m_min) return W_OP;
        if (m_wt >= m_max) return W_CL;
        return W_HF;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (!m_in_frame) begin
            if (b == 8'h30) begin
                m_in_frame = 1;
                m_digits.delete();
            end
        end else if (b >= 8'h30 && b <= 8'h39) begin
            m_digits.push_back(int'(b) - 48);
            if (m_digits.size() == 6) begin
                m_min = m_digits[0] * 10 + m_digits[1];
                m_max = m_digits[2] * 10 + m_digits[3];
                m_wt  = m_digits[4] * 10 + m_digits[5];
                m_in_frame = 0;
            end
        end else begin
            m_in_frame = 0;
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_max = 0; m_wt = 0; m_in_frame = 0;
        m_digits.delete();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic uart_tx(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            entrada_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        entrada_serial = stop_bit;
        repeat (CPB) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        uart_tx(b, 1'b1);
        model_byte(b);
    endtask

    task automatic send_cmd(input int mn, input int mx, input int wt);
        send(8'h30);
        send(8'(48 + mn / 10)); send(8'(48 + mn % 10));
        send(8'(48 + mx / 10)); send(8'(48 + mx % 10));
        send(8'(48 + wt / 10)); send(8'(48 + wt % 10));
    endtask

    // Two frames after the last byte the in-progress frame is guaranteed to use the new width.
    task automatic settle_and_expect();
        int n;
        repeat (2 * PER) @(negedge clock);
        exp_q.push_back(model_width());
        n = 0;
        while (exp_q.size() != 0 && n < 3 * PER) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no pwm frame within %0d clocks, expected one", 3 * PER);
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        logic prev;
        int hi, per;
        bit have;
        prev = 1'b0; hi = 0; per = 0; have = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                have = 0;
            end else if (pwm && !prev) begin
                if (have && exp_q.size() != 0) begin
                    int e;
                    e = exp_q.pop_front();
                    check("pwm_high", hi, e);
                    check("pwm_period", per, PER);
                end
                hi = 1; per = 1; have = 1;
            end else begin
                per++;
                if (pwm) hi++;
            end
            prev = pwm;
        end
    end

    initial begin : stimulus
        repeat (10) @(negedge clock);
        check("pwm_in_reset", int'(pwm), 0);
        reset = 1'b0;
        @(negedge clock);
        check("pwm_first_clk", int'(pwm), 1);
        settle_and_expect();

        send_cmd(10, 20, 15); settle_and_expect();
        send_cmd(10, 20, 5);  settle_and_expect();
        send_cmd(10, 20, 20); settle_and_expect();

        send(8'h30); send(8'h31); send(8'h41); send(8'h32); send(8'h30);
        settle_and_expect();

        // Start glitch and a framing-error byte in the middle of a frame are both invisible
        send(8'h30); send(8'h31); send(8'h30);
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (2) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        uart_tx(8'h39, 1'b0);
        send(8'h32); send(8'h30); send(8'h31); send(8'h35);
        settle_and_expect();

        send_cmd(50, 10, 30); settle_and_expect();
        send_cmd(50, 10, 60); settle_and_expect();
        send_cmd(10, 20, 15); settle_and_expect();

        send(8'h30); send(8'h31); send(8'h30); send(8'h32);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("pwm_async_reset", int'(pwm), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("pwm_after_reset", int'(pwm), 1);
        send(8'h30); send(8'h31); send(8'h35);
        settle_and_expect();

        for (int k = 0; k < 6; k++) begin
            logic [7:0] bytes [7];
            int mn, mx, wt;
            mn = $urandom_range(99); mx = $urandom_range(99); wt = $urandom_range(99);
            bytes[0] = 8'h30;
            bytes[1] = 8'(48 + mn / 10); bytes[2] = 8'(48 + mn % 10);
            bytes[3] = 8'(48 + mx / 10); bytes[4] = 8'(48 + mx % 10);
            bytes[5] = 8'(48 + wt / 10); bytes[6] = 8'(48 + wt % 10);
            if ($urandom_range(2) == 0)
                bytes[$urandom_range(6, 1)] = 8'($urandom_range(8'h7E, 8'h3A));
            for (int j = 0; j < 7; j++) send(bytes[j]);
            settle_and_expect();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
